// File: rtl/channel_acq_responder.sv
// Circular-buffer ADC acquisition with a trigger/done handshake and a framed readout stream.
// Stream words come from registers and hold while out_ready is low. The header appears one cycle after POST completes.
`timescale 1ns/1ps
module channel_acq_responder #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    acq_enable,
   input  logic          acq_trig,
   output logic          acq_done,
   input  logic          adc_valid,
   input  logic [11:0]   adc_data,
   input  logic [AW-1:0] pre_len,
   input  logic [AW-1:0] post_len,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic          out_last,
   output logic [3:0]    state
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_POST    = 4'b0010,
      S_READOUT = 4'b0100,
      S_DONE    = 4'b1000
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [11:0]   r_mem [0:(1<<AW)-1];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_fill_cnt;
   logic [AW-1:0] r_post_len;
   logic [AW-1:0] r_post_cnt;
   logic [AW:0]   r_eff_pre;
   logic [AW:0]   r_remain;
   logic          r_out_valid;
   logic          r_out_last;
   logic [31:0]   r_out_data;

   logic          w_en;
   logic          w_unused;
   logic          w_wr_idle;
   logic          w_wr_post;
   logic          w_wr_en;
   logic          w_accept;
   logic          w_post_done;
   logic          w_xfer;
   logic          w_leave_done;
   logic [AW:0]   w_fill_inc;
   logic [AW:0]   w_fill_now;
   logic [AW:0]   w_room;
   logic [AW:0]   w_pre_ext;
   logic [AW:0]   w_min_a;
   logic [AW:0]   w_eff_pre;
   logic [AW:0]   w_win;
   logic [AW-1:0] w_rd_start;

   assign w_en        = acq_enable[0];
   assign w_unused    = acq_enable[1];
   assign w_wr_idle   = (r_state == S_IDLE) && w_en && adc_valid;
   assign w_post_done = (r_state == S_POST) && (r_post_cnt == r_post_len);
   assign w_wr_post   = (r_state == S_POST) && adc_valid && (r_post_cnt != r_post_len);
   assign w_wr_en     = w_wr_idle || w_wr_post;
   assign w_accept    = (r_state == S_IDLE) && acq_trig && w_en;
   assign w_xfer      = (r_state == S_READOUT) && r_out_valid && out_ready;
   assign w_leave_done = (r_state == S_DONE) && !acq_trig;

   // A sample landing in the acceptance cycle already counts toward the pre-trigger fill.
   assign w_fill_inc = (r_fill_cnt == DEPTH) ? r_fill_cnt : r_fill_cnt + ONE;
   assign w_fill_now = w_wr_idle ? w_fill_inc : r_fill_cnt;
   assign w_room     = DEPTH - {1'b0, post_len};
   assign w_pre_ext  = {1'b0, pre_len};
   assign w_min_a    = (w_pre_ext < w_fill_now) ? w_pre_ext : w_fill_now;
   assign w_eff_pre  = (w_min_a < w_room) ? w_min_a : w_room;

   assign w_win      = r_eff_pre + {1'b0, r_post_len};
   assign w_rd_start = r_wr_ptr - w_win[AW-1:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (acq_trig) w_next = w_en ? S_POST : S_DONE;
         S_POST:    if (w_post_done) w_next = S_READOUT;
         S_READOUT: if (w_xfer && r_out_last) w_next = S_DONE;
         S_DONE:    if (!acq_trig) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= adc_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_fill_cnt  <= '0;
         r_post_len  <= '0;
         r_post_cnt  <= '0;
         r_eff_pre   <= '0;
         r_remain    <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;

         if (!w_en || w_leave_done) r_fill_cnt <= '0;
         else if (w_wr_idle)        r_fill_cnt <= w_fill_inc;

         if (w_accept) begin
            r_post_len <= post_len;
            r_eff_pre  <= w_eff_pre;
            r_post_cnt <= '0;
         end else if (w_wr_post) begin
            r_post_cnt <= r_post_cnt + 1'b1;
         end

         // The window ends at the final write pointer; the header is staged while POST exits.
         if (w_post_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {16'hCBF0, 16'(w_win)};
            r_out_last  <= (w_win == '0);
            r_rd_ptr    <= w_rd_start;
            r_remain    <= w_win;
         end else if (w_xfer) begin
            if (r_out_last) begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               r_out_data  <= '0;
            end else begin
               r_out_data  <= {20'd0, r_mem[r_rd_ptr]};
               r_rd_ptr    <= r_rd_ptr + 1'b1;
               r_remain    <= r_remain - ONE;
               r_out_last  <= (r_remain == ONE);
            end
         end
      end
   end

   assign acq_done  = (r_state == S_DONE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign state     = r_state;

endmodule

// File: tb/tb_channel_acq_responder.sv
// Directed bench: two instances (AW=10 and AW=4) share stimulus and must both produce the expected stream.
`timescale 1ns/1ps
module tb_channel_acq_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  acq_enable;
   logic        acq_trig;
   logic        adc_valid;
   logic [11:0] adc_data;
   logic [9:0]  pre_len;
   logic [9:0]  post_len;
   logic        out_ready;

   logic        a_done, a_valid, a_last;
   logic [31:0] a_data;
   logic [3:0]  a_state;
   logic        b_done, b_valid, b_last;
   logic [31:0] b_data;
   logic [3:0]  b_state;

   int n_chk  = 0;
   int n_fail = 0;

   always #12.5 clk = ~clk;

   channel_acq_responder #(.AW(10)) u_dut (
      .clk(clk), .reset(reset), .acq_enable(acq_enable), .acq_trig(acq_trig),
      .acq_done(a_done), .adc_valid(adc_valid), .adc_data(adc_data),
      .pre_len(pre_len), .post_len(post_len), .out_valid(a_valid),
      .out_ready(out_ready), .out_data(a_data), .out_last(a_last), .state(a_state)
   );

   channel_acq_responder #(.AW(4)) u_dut4 (
      .clk(clk), .reset(reset), .acq_enable(acq_enable), .acq_trig(acq_trig),
      .acq_done(b_done), .adc_valid(adc_valid), .adc_data(adc_data),
      .pre_len(pre_len[3:0]), .post_len(post_len[3:0]), .out_valid(b_valid),
      .out_ready(out_ready), .out_data(b_data), .out_last(b_last), .state(b_state)
   );

   typedef struct {
      int         n_pre;
      bit         samp_trig;
      int         pre;
      int         post;
      int         n_post;
      logic [1:0] en;
      bit         drop;
      bit         stall;
      int         exp_w;
      int         exp_first;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int          val;
      int          idx;
      int          cyc;
      bit          r;
      logic [31:0] e;
      acq_enable = 2'b10;
      adc_valid  = 1'b0;
      acq_trig   = 1'b0;
      out_ready  = 1'b0;
      step();
      acq_enable = v.en;
      val = 0;
      for (int i = 0; i < v.n_pre; i++) begin
         adc_valid = 1'b1;
         adc_data  = 12'(val);
         val++;
         step();
      end
      adc_valid = v.samp_trig;
      adc_data  = 12'(val);
      if (v.samp_trig) val++;
      pre_len  = 10'(v.pre);
      post_len = 10'(v.post);
      acq_trig = 1'b1;
      step();
      adc_valid = 1'b0;
      chk($sformatf("v%0d post state a", k), {28'd0, a_state}, 32'h2);
      chk($sformatf("v%0d post state b", k), {28'd0, b_state}, 32'h2);
      if (v.drop) acq_trig = 1'b0;
      for (int i = 0; i < v.n_post; i++) begin
         adc_valid = 1'b1;
         adc_data  = 12'(val);
         val++;
         step();
      end
      // Junk samples keep arriving through readout and must never reach the buffer.
      adc_valid = 1'b1;
      adc_data  = 12'hABC;
      idx = 0;
      cyc = 0;
      while (idx <= v.exp_w && cyc < 300) begin
         if (a_valid) begin
            if (idx == 0) e = {16'hCBF0, 16'(v.exp_w)};
            else          e = {20'd0, 12'(v.exp_first + idx - 1)};
            chk($sformatf("v%0d word%0d data a", k, idx), a_data, e);
            chk($sformatf("v%0d word%0d data b", k, idx), b_data, e);
            chk($sformatf("v%0d word%0d last a", k, idx), {31'd0, a_last}, {31'd0, idx == v.exp_w});
            chk($sformatf("v%0d word%0d valid b", k, idx), {31'd0, b_valid}, 32'd1);
            r = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (r) idx++;
         end else begin
            out_ready = 1'b0;
         end
         step();
         cyc++;
      end
      out_ready = 1'b0;
      if (idx <= v.exp_w) chk($sformatf("v%0d readout timeout words", k), 32'(idx), 32'(v.exp_w + 1));
      adc_valid = 1'b0;
      chk($sformatf("v%0d done state a", k), {28'd0, a_state}, 32'h8);
      chk($sformatf("v%0d done state b", k), {28'd0, b_state}, 32'h8);
      chk($sformatf("v%0d acq_done", k), {31'd0, a_done}, 32'd1);
      chk($sformatf("v%0d valid after last", k), {31'd0, a_valid}, 32'd0);
      if (!v.drop) begin
         step();
         chk($sformatf("v%0d done held", k), {30'd0, a_done, b_done}, 32'h3);
      end
      acq_trig = 1'b0;
      step();
      chk($sformatf("v%0d idle state a", k), {28'd0, a_state}, 32'h1);
      chk($sformatf("v%0d idle state b", k), {28'd0, b_state}, 32'h1);
      chk($sformatf("v%0d done cleared", k), {30'd0, a_done, b_done}, 32'h0);
   endtask

   initial begin
      int val;
      int cyc;
      tbl[0] = '{20, 1'b0, 4,  3, 3, 2'b01, 1'b0, 1'b0, 7,  16};
      tbl[1] = '{2,  1'b0, 8,  2, 2, 2'b01, 1'b0, 1'b0, 4,  0};
      tbl[2] = '{40, 1'b0, 10, 6, 6, 2'b11, 1'b0, 1'b0, 16, 30};
      tbl[3] = '{5,  1'b0, 0,  0, 0, 2'b01, 1'b0, 1'b0, 0,  0};
      tbl[4] = '{3,  1'b0, 7,  0, 0, 2'b01, 1'b1, 1'b0, 3,  0};
      tbl[5] = '{4,  1'b1, 5,  1, 1, 2'b01, 1'b0, 1'b0, 6,  0};
      tbl[6] = '{20, 1'b0, 4,  3, 3, 2'b01, 1'b1, 1'b1, 7,  16};
      tbl[7] = '{40, 1'b0, 10, 6, 6, 2'b01, 1'b0, 1'b1, 16, 30};

      reset      = 1'b1;
      acq_enable = 2'b00;
      acq_trig   = 1'b0;
      adc_valid  = 1'b0;
      adc_data   = '0;
      pre_len    = '0;
      post_len   = '0;
      out_ready  = 1'b0;
      #1 reset = 1'b0;
      step();
      step();
      chk("reset state a", {28'd0, a_state}, 32'h1);
      chk("reset state b", {28'd0, b_state}, 32'h1);
      chk("reset done/valid/last", {26'd0, a_done, a_valid, a_last, b_done, b_valid, b_last}, 32'h0);
      chk("reset data a", a_data, 32'h0);
      reset = 1'b1;
      step();

      for (int k = 0; k < 8; k++) run_vec(k, tbl[k]);

      // Trigger while acquisition is disabled (bit1 alone must not enable it).
      acq_enable = 2'b10;
      acq_trig   = 1'b1;
      step();
      chk("dis done state", {28'd0, a_state}, 32'h8);
      chk("dis acq_done", {30'd0, a_done, b_done}, 32'h3);
      chk("dis no valid", {30'd0, a_valid, b_valid}, 32'h0);
      step();
      chk("dis held no valid", {30'd0, a_valid, a_done}, 32'h1);
      acq_trig = 1'b0;
      step();
      chk("dis back idle", {28'd0, a_state}, 32'h1);
      chk("dis done cleared", {31'd0, a_done}, 32'd0);

      // Reset in the middle of a stalled readout.
      acq_enable = 2'b01;
      val = 0;
      for (int i = 0; i < 20; i++) begin
         adc_valid = 1'b1;
         adc_data  = 12'(val);
         val++;
         step();
      end
      adc_valid = 1'b0;
      pre_len   = 10'd4;
      post_len  = 10'd3;
      acq_trig  = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         adc_valid = 1'b1;
         adc_data  = 12'(val);
         val++;
         step();
      end
      adc_valid = 1'b0;
      cyc = 0;
      while (!a_valid && cyc < 50) begin
         step();
         cyc++;
      end
      chk("rst seq header", a_data, 32'hCBF00007);
      #3 reset = 1'b0;
      #1;
      chk("rst seq valid", {30'd0, a_valid, b_valid}, 32'h0);
      chk("rst seq state", {28'd0, a_state}, 32'h1);
      chk("rst seq done/last", {30'd0, a_done, a_last}, 32'h0);
      chk("rst seq data", a_data, 32'h0);
      step();
      reset     = 1'b1;
      acq_trig  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst seq stays quiet", {29'd0, a_valid, b_valid, a_done}, 32'h0);
      chk("rst seq idle", {28'd0, a_state}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
